// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin N:1 arbiter for AXI4 AW/W/B channels.
// One master owns the slave from grant until its B handshake completes.
module axi_wr_arbiter #(
  parameter int NM = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETn,
  input  logic [NM*(ADDR_WIDTH+13)-1:0]            M_AWPAYLOAD,
  input  logic [NM-1:0]                            M_AWVALID,
  output logic [NM-1:0]                            M_AWREADY,
  input  logic [NM*(DATA_WIDTH+DATA_WIDTH/8+1)-1:0] M_WPAYLOAD,
  input  logic [NM-1:0]                            M_WVALID,
  output logic [NM-1:0]                            M_WREADY,
  output logic [1:0]                               M_BRESP,
  output logic [NM-1:0]                            M_BVALID,
  input  logic [NM-1:0]                            M_BREADY,
  output logic [ADDR_WIDTH+12:0]                   S_AWPAYLOAD,
  output logic                                     S_AWVALID,
  input  logic                                     S_AWREADY,
  output logic [DATA_WIDTH+DATA_WIDTH/8:0]         S_WPAYLOAD,
  output logic                                     S_WVALID,
  input  logic                                     S_WREADY,
  input  logic [1:0]                               S_BRESP,
  input  logic                                     S_BVALID,
  output logic                                     S_BREADY,
  output logic [NM-1:0]                            GRANT,
  output logic                                     BUSY
);
  localparam int AWW = ADDR_WIDTH + 13;
  localparam int WPW = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  state_t state;
  logic [GW-1:0] g, last_grant, nxt;
  logic [NM-1:0] nxt_oh;
  logic found, w_fwd;
  int idx;
  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    nxt = last_grant;
    nxt_oh = '0;
    found = 1'b0;
    idx = 0;
    for (int k = NM; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NM;
      if (M_AWVALID[idx]) begin
        nxt = GW'(idx);
        nxt_oh = '0;
        nxt_oh[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
      GRANT <= '0;
      BUSY <= 1'b0;
      g <= '0;
      last_grant <= GW'(NM - 1);
    end else begin
      case (state)
        IDLE: if (found) begin
          g <= nxt;
          GRANT <= nxt_oh;
          BUSY <= 1'b1;
          state <= AW;
        end
        AW: if (S_AWVALID && S_AWREADY) state <= W;
        W: if (S_BVALID || (S_WVALID && S_WREADY && S_WPAYLOAD[0])) state <= B;
        default: if (S_BVALID && S_BREADY) begin
          last_grant <= g;
          GRANT <= '0;
          BUSY <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  // An early B from the slave cuts off W forwarding in the same cycle.
  assign w_fwd = (state == W) && !S_BVALID;
  assign S_AWVALID = (state == AW) && M_AWVALID[g];
  assign M_AWREADY = (state == AW) ? GRANT & {NM{S_AWREADY}} : '0;
  assign S_AWPAYLOAD = (state != IDLE) ? M_AWPAYLOAD[g*AWW +: AWW] : '0;
  assign S_WVALID = w_fwd && M_WVALID[g];
  assign M_WREADY = w_fwd ? GRANT & {NM{S_WREADY}} : '0;
  assign S_WPAYLOAD = (state != IDLE) ? M_WPAYLOAD[g*WPW +: WPW] : '0;
  assign M_BVALID = (state == B) ? GRANT & {NM{S_BVALID}} : '0;
  assign M_BRESP = S_BRESP;
  assign S_BREADY = (state == B) && M_BREADY[g];
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: directed bench with a transaction-level ownership model
// checked every cycle, plus literal checks on grant order and responses.
module tb_axi_wr_arbiter;
  localparam int NM = 2;
  localparam int AWW = 45;
  localparam int WPW = 37;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [AWW-1:0] aw_pl [NM];
  logic [WPW-1:0] w_pl [NM];
  logic [NM-1:0] aw_valid = '0, w_valid = '0, b_ready = '0;
  logic s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0;
  logic [1:0] s_bresp = 2'b00;
  logic [NM-1:0] m_awready, m_wready, m_bvalid, grant;
  logic [1:0] m_bresp;
  logic [AWW-1:0] s_awpayload;
  logic [WPW-1:0] s_wpayload;
  logic s_awvalid, s_wvalid, s_bready, busy;
  int n_chk = 0, n_fail = 0;
  int owner = -1, stage = 0, last = NM - 1, whs = 0;
  int grant_seq[$];
  logic [NM-1:0] prev_grant = '0;

  axi_wr_arbiter #(.NM(NM), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M_AWPAYLOAD({aw_pl[1], aw_pl[0]}), .M_AWVALID(aw_valid), .M_AWREADY(m_awready),
    .M_WPAYLOAD({w_pl[1], w_pl[0]}), .M_WVALID(w_valid), .M_WREADY(m_wready),
    .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .M_BREADY(b_ready),
    .S_AWPAYLOAD(s_awpayload), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
    .S_WPAYLOAD(s_wpayload), .S_WVALID(s_wvalid), .S_WREADY(s_wready),
    .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
    .GRANT(grant), .BUSY(busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the slave and how far its transaction has progressed
  // (0 address pending, 1 data pending, 2 response pending).
  always @(negedge ACLK) begin
    int o;
    bit own;
    logic [NM-1:0] oh;
    if (!ARESETn) begin
      owner = -1;
      stage = 0;
      last = NM - 1;
    end
    own = owner >= 0;
    o = own ? owner : 0;
    oh = own ? NM'(1) << o : '0;
    chk("GRANT", grant, oh);
    chk("BUSY", busy, own);
    chk("S_AWVALID", s_awvalid, own && stage == 0 && aw_valid[o]);
    chk("M_AWREADY", m_awready, (own && stage == 0 && s_awready) ? oh : '0);
    chk("S_AWPAYLOAD", s_awpayload, own ? aw_pl[o] : '0);
    chk("S_WVALID", s_wvalid, own && stage == 1 && !s_bvalid && w_valid[o]);
    chk("M_WREADY", m_wready, (own && stage == 1 && !s_bvalid && s_wready) ? oh : '0);
    chk("S_WPAYLOAD", s_wpayload, own ? w_pl[o] : '0);
    chk("M_BVALID", m_bvalid, (own && stage == 2 && s_bvalid) ? oh : '0);
    chk("S_BREADY", s_bready, own && stage == 2 && b_ready[o]);
    chk("M_BRESP", m_bresp, s_bresp);
    if (s_wvalid && s_wready) whs++;
    if (grant != '0 && prev_grant == '0) grant_seq.push_back(grant[1] ? 1 : 0);
    prev_grant = grant;
    if (ARESETn) begin
      if (!own) begin
        for (int k = 1; k <= NM; k++)
          if (aw_valid[(last + k) % NM]) begin
            owner = (last + k) % NM;
            stage = 0;
            break;
          end
      end else if (stage == 0) begin
        if (aw_valid[o] && s_awready) stage = 1;
      end else if (stage == 1) begin
        if (s_bvalid || (w_valid[o] && s_wready && w_pl[o][0])) stage = 2;
      end else if (s_bvalid && b_ready[o]) begin
        last = owner;
        owner = -1;
      end
    end
  end

  task automatic do_reset();
    @(posedge ACLK);
    #2 ARESETn = 1'b0;
    @(posedge ACLK);
    #3 ARESETn = 1'b1;
  endtask

  task automatic wait_grant(input int m, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(posedge ACLK);
      #1 ok = grant[m];
    end
    chk("grant_wait", ok, 1'b1);
  endtask

  // Master m runs one burst; early >= 0 makes the slave answer B at that beat.
  task automatic burst(input int m, input logic [31:0] addr, input int beats, input int last_beat,
                       input int early, input logic [1:0] resp, input int bdelay, input logic [7:0] d0);
    bit ok;
    aw_pl[m] = {addr, 8'(beats - 1), 3'd2, 2'b01};
    aw_valid[m] = 1'b1;
    wait_grant(m, ok);
    if (!ok) return;
    chk("grant_onehot", grant, NM'(1) << m);
    s_awready = 1'b1;
    @(posedge ACLK);
    #1 aw_valid[m] = 1'b0;
    s_awready = 1'b0;
    for (int b = 0; b < beats; b++) begin
      w_pl[m] = {32'(d0 + 8'(b)), 4'hF, b == last_beat};
      w_valid[m] = 1'b1;
      if (b == early) begin
        s_bresp = resp;
        s_bvalid = 1'b1;
        @(posedge ACLK);
        #1 break;
      end
      s_wready = 1'b1;
      @(posedge ACLK);
      #1 s_wready = 1'b0;
      if (b == last_beat) break;
    end
    s_bresp = resp;
    s_bvalid = 1'b1;
    #1;
    chk("bvalid_m", m_bvalid, NM'(1) << m);
    chk("bresp_m", m_bresp, resp);
    repeat (bdelay) begin
      @(posedge ACLK);
      #1 chk("bp_sbready", s_bready, 1'b0);
      chk("bp_grant", grant, NM'(1) << m);
    end
    b_ready[m] = 1'b1;
    @(posedge ACLK);
    #1 s_bvalid = 1'b0;
    b_ready[m] = 1'b0;
    w_valid[m] = 1'b0;
    chk("grant_released", grant, '0);
  endtask

  initial begin
    int w0;
    bit ok;
    int exp_seq[12] = '{0, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 1};
    aw_pl[0] = '0; aw_pl[1] = '0; w_pl[0] = '0; w_pl[1] = '0;
    #12;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_awready", m_awready, 2'b00);
    chk("rst_savalid", s_awvalid, 1'b0);
    #6 ARESETn = 1'b1;
    // Single master, 4-beat INCR burst at 0x10
    w0 = whs;
    burst(0, 32'h10, 4, 3, -1, 2'b00, 0, 8'hA0);
    chk("s1_beats", whs - w0, 4);
    chk("s1_payload_last", w_pl[0], {32'hA3, 4'hF, 1'b1});
    // Simultaneous requests after reset: 0, then 1, then 0 again
    do_reset();
    aw_pl[1] = {32'h200, 8'd1, 3'd2, 2'b01};
    aw_valid[1] = 1'b1;
    burst(0, 32'h100, 2, 1, -1, 2'b00, 0, 8'h10);
    aw_pl[0] = {32'h300, 8'd0, 3'd2, 2'b01};
    aw_valid[0] = 1'b1;
    burst(1, 32'h200, 2, 1, -1, 2'b01, 0, 8'h20);
    burst(0, 32'h300, 1, 0, -1, 2'b00, 0, 8'h30);
    // Master 1 requests while master 0 is mid-burst
    fork
      burst(0, 32'h400, 4, 3, -1, 2'b00, 0, 8'h40);
      begin
        repeat (3) @(posedge ACLK);
        #1 aw_pl[1] = {32'h500, 8'd0, 3'd2, 2'b01};
        aw_valid[1] = 1'b1;
      end
    join
    burst(1, 32'h500, 1, 0, -1, 2'b00, 0, 8'h50);
    // WLAST on beat 2 of a 4-beat burst, slave answers SLVERR
    w0 = whs;
    burst(0, 32'h600, 4, 1, -1, 2'b10, 0, 8'h60);
    chk("s4_beats", whs - w0, 2);
    // Slave raises BVALID during beat 3: W forwarding stops
    w0 = whs;
    burst(1, 32'h700, 4, -1, 2, 2'b10, 0, 8'h70);
    chk("s4b_beats", whs - w0, 2);
    // BREADY backpressure for 5 cycles
    burst(1, 32'h800, 2, 1, -1, 2'b00, 5, 8'h80);
    // Asynchronous reset during beat 2 of master 1's burst
    aw_pl[1] = {32'h900, 8'd3, 3'd2, 2'b01};
    aw_valid[1] = 1'b1;
    wait_grant(1, ok);
    s_awready = 1'b1;
    @(posedge ACLK);
    #1 aw_valid[1] = 1'b0;
    s_awready = 1'b0;
    w_pl[1] = {32'h90, 4'hF, 1'b0};
    w_valid[1] = 1'b1;
    s_wready = 1'b1;
    @(posedge ACLK);
    #1 w_pl[1] = {32'h91, 4'hF, 1'b0};
    #1 ARESETn = 1'b0;
    #1;
    chk("arst_grant", grant, 2'b00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_swvalid", s_wvalid, 1'b0);
    chk("arst_mwready", m_wready, 2'b00);
    chk("arst_swpayload", s_wpayload, '0);
    w_valid[1] = 1'b0;
    s_wready = 1'b0;
    @(posedge ACLK);
    #3 ARESETn = 1'b1;
    aw_pl[1] = {32'hA00, 8'd0, 3'd2, 2'b01};
    aw_valid[1] = 1'b1;
    burst(0, 32'hB00, 1, 0, -1, 2'b00, 0, 8'hB0);
    burst(1, 32'hA00, 1, 0, -1, 2'b11, 0, 8'hA8);
    repeat (2) @(posedge ACLK);
    #1 chk("grant_count", grant_seq.size(), 12);
    for (int i = 0; i < 12 && i < grant_seq.size(); i++) chk($sformatf("grant_seq[%0d]", i), grant_seq[i], exp_seq[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
